// File: rtl/switch_ctrl_gen_if.sv
// Handshake bundle between a beat source and the switch control generator.
// The master drives beats in and observes switch control and output flags.
interface switch_ctrl_gen_if;
    logic in_valid;
    logic in_sop;
    logic mode;
    logic ctrl;
    logic out_valid;
    logic out_sop;
    logic out_eop;
    logic frame_err;

    modport master (
        output in_valid, in_sop, mode,
        input  ctrl, out_valid, out_sop, out_eop, frame_err
    );

    modport slave (
        input  in_valid, in_sop, mode,
        output ctrl, out_valid, out_sop, out_eop, frame_err
    );
endinterface

// File: rtl/switch_ctrl_gen.sv
// Control generator for one column of registered 2x2 switches: frames beats,
// derives the cross/straight bit from the beat index and aligns flags with switch outputs.
module switch_ctrl_gen #(
    parameter int FRAME_BEATS = 512,
    parameter int PERIOD_LOG  = 0,
    parameter int CTRL_DELAY  = 1
) (
    input logic         clk,
    input logic         rst,
    switch_ctrl_gen_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BEATS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             frame_err_q, frame_err_d;
    logic [CTRL_DELAY-1:0] ctrl_pipe_q, ctrl_pipe_d;
    logic [CTRL_DELAY:0]   valid_pipe_q, valid_pipe_d;
    logic [CTRL_DELAY:0]   sop_pipe_q, sop_pipe_d;
    logic [CTRL_DELAY:0]   eop_pipe_q, eop_pipe_d;

    logic accept;
    logic is_sop;
    logic is_eop;
    logic raw_ctrl;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        frame_err_d = 1'b0;
        accept      = 1'b0;
        is_sop      = 1'b0;
        is_eop      = 1'b0;
        raw_ctrl    = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sop) begin
                // A sop always restarts the frame; inside RUN it is also a protocol error.
                accept      = 1'b1;
                is_sop      = 1'b1;
                raw_ctrl    = bus.mode;
                state_d     = RUN;
                cnt_d       = CNT_W'(1);
                mode_d      = bus.mode;
                frame_err_d = (state_q == RUN);
            end else if (state_q == RUN) begin
                accept   = 1'b1;
                raw_ctrl = cnt_q[PERIOD_LOG] ^ mode_q;
                if (cnt_q == LAST_IDX) begin
                    is_eop  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_pipe_d    = '0;
        ctrl_pipe_d[0] = raw_ctrl;
        for (int i = 1; i < CTRL_DELAY; i++) begin
            ctrl_pipe_d[i] = ctrl_pipe_q[i-1];
        end
        // Flags take one extra stage to match the switch output register.
        valid_pipe_d = {valid_pipe_q[CTRL_DELAY-1:0], accept};
        sop_pipe_d   = {sop_pipe_q[CTRL_DELAY-1:0], is_sop};
        eop_pipe_d   = {eop_pipe_q[CTRL_DELAY-1:0], is_eop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            ctrl_pipe_q  <= '0;
            valid_pipe_q <= '0;
            sop_pipe_q   <= '0;
            eop_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            frame_err_q  <= frame_err_d;
            ctrl_pipe_q  <= ctrl_pipe_d;
            valid_pipe_q <= valid_pipe_d;
            sop_pipe_q   <= sop_pipe_d;
            eop_pipe_q   <= eop_pipe_d;
        end
    end

    assign bus.ctrl      = ctrl_pipe_q[CTRL_DELAY-1];
    assign bus.out_valid = valid_pipe_q[CTRL_DELAY];
    assign bus.out_sop   = sop_pipe_q[CTRL_DELAY];
    assign bus.out_eop   = eop_pipe_q[CTRL_DELAY];
    assign bus.frame_err = frame_err_q;
endmodule

// File: doc/switch_ctrl_gen.md
Name: switch_ctrl_gen

Overview:
Control-side driver for a column of registered 2x2 switches (one-cycle data latency, ctrl=0 straight, ctrl=1 cross) in the streaming permutation network.
- Tracks frames of valid beats and generates the switch ctrl bit from a beat counter, selecting forward or inverse permutation.
- Delays ctrl to arrive in step with data reaching the switch inputs.
- Emits valid/sop/eop flags aligned with the switch outputs for the downstream stage.

Parameters:
FRAME_BEATS, 512, beats per frame; power of two, >= 2.
PERIOD_LOG, 0, ctrl toggles every 2^PERIOD_LOG counted beats; must be < log2(FRAME_BEATS).
CTRL_DELAY, 1, cycles from beat acceptance to ctrl presentation at switch input; >= 1.
CNT_W, $clog2(FRAME_BEATS), beat counter width (derived; do not override).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  data beat present at pipeline entry this cycle
in_sop  in  1  first beat of a frame; qualified by in_valid
mode  in  1  0 forward, 1 inverse (ctrl polarity inverted); sampled on the sop beat only
ctrl  out  1  switch control, valid CTRL_DELAY cycles after the beat
out_valid  out  1  switch output holds a valid beat
out_sop  out  1  switch output beat is frame start
out_eop  out  1  switch output beat is frame end
frame_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (asynchronous assert, synchronous-edge release): all outputs 0, FSM=IDLE, counter=0, mode_q=0, all delay stages cleared. Asserting rst mid-frame drops outputs to 0 immediately and discards the frame in flight.
- FSM states:
  - IDLE: in_valid & in_sop -> RUN, counter<=1, mode_q<=mode. The beat is counted as index 0.
  - IDLE: in_valid & !in_sop -> stay IDLE, beat dropped (no out_valid), frame_err pulses.
  - RUN, in_valid & !in_sop: counter<=counter+1. If counter==FRAME_BEATS-1, the beat is eop; go to IDLE and set counter<=0.
  - RUN, in_valid & in_sop: frame_err pulses; restart at index 0, counter<=1, mode_q<=mode. The beat is treated as sop.
  - FRAME_BEATS==2 edge: the beat after sop is eop.
  - in_valid=0: counter, FSM and mode_q hold; bubbles are allowed anywhere.
- Beat index idx = counter value before increment (0 on sop beat).
- Raw ctrl = idx[PERIOD_LOG] XOR effective mode, where effective mode = mode on a sop beat, else mode_q. Raw ctrl = 0 for non-valid or dropped beats.
- ctrl: raw ctrl through CTRL_DELAY register stages. A beat accepted at cycle T drives ctrl during cycle T+CTRL_DELAY.
- out_valid/out_sop/out_eop: accepted-beat flags through CTRL_DELAY+1 stages, matching the switch output register. Beat at T appears at T+CTRL_DELAY+1.
- frame_err: registered, asserted during cycle T+1 for a violating beat at T; not delayed with data.
- Counter wraps only via eop return to IDLE; no modulo overflow path exists.
- Back-to-back frames: sop on the cycle after eop is legal, with no error and no gap.

Test Plan:
- FRAME_BEATS=8, PERIOD_LOG=1, CTRL_DELAY=2, mode=0, 8 consecutive beats from T=0 -> ctrl over cycles 2..9 = 0,0,1,1,0,0,1,1; out_valid cycles 3..10; out_sop at 3 only; out_eop at 10 only; frame_err never.
- Same, mode=1 on sop, mode toggled mid-frame -> ctrl = 1,1,0,0,1,1,0,0; the mid-frame mode change has no effect.
- Same frame with in_valid=0 on cycles 2 and 5 -> ctrl pattern per valid beat unchanged; out_valid low at cycles 5 and 8; eop on the 8th valid beat.
- sop re-asserted on beat index 5 -> frame_err high one cycle later; that beat's ctrl = 0 (index 0); eop follows 7 beats later.
- in_valid=1, in_sop=0 while IDLE -> frame_err pulse; out_valid stays 0; next sop frame is normal.
- rst asserted mid-frame between clock edges -> all outputs 0 before the next edge; after release, a new sop frame starts at index 0 with correct alignment.
